seg_display_scheduler: RTL and testbench

Sequences the 7-segment display. Two requesters share one display queue: port A is the CPU store path to the segment address, port B is a debug/test source. The block arbitrates their pushes into a DEPTH-entry FIFO of 24-bit display words and shows each word on seg_out for exactly DWELL_CYCLES clocks, oldest first. It sits between the IO decode logic and the segment driver.

---
 rtl/seg_display_scheduler.sv | 244 ++++++++++++++++++++++++
 tb/tb_seg_display_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scheduler.sv
// Two-port arbitrated display queue that shows each word on seg_out for DWELL_CYCLES clocks.
// Define SEG_SCHED_GAP_EN to insert GAP_CYCLES blank clocks after every word.
module seg_display_scheduler #(
  parameter int DATA_W       = 24,
  parameter int DEPTH        = 32,
  parameter int DWELL_CYCLES = 100000000,
  parameter int GAP_CYCLES   = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_a,
  input  logic [DATA_W-1:0]        data_a,
  input  logic                     req_b,
  input  logic [DATA_W-1:0]        data_b,
  output logic                     gnt_a,
  output logic                     gnt_b,
  input  logic                     flush,
  output logic [DATA_W-1:0]        seg_out,
  output logic                     busy,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL_CYCLES - 1);
`ifdef SEG_SCHED_GAP_EN
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [DATA_W-1:0]   seg_q, seg_d;
  logic                busy_q, busy_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                prio_a_q, prio_a_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                full_s, empty_s, can_push_s, push_s, pop_s, timeout_s, multi_s;
  logic [DATA_W-1:0]   wdata_s, head_s, next_s;
  logic [AW-1:0]       rd_ptr_inc_s;

  // Round-robin arbiter: priority only moves when both ports contend.
  always_comb begin
    full_s     = (count_q == CW'(DEPTH));
    empty_s    = (count_q == {CW{1'b0}});
    can_push_s = rst_n & ~flush & ~full_s;
    gnt_a      = can_push_s & req_a & (~req_b | prio_a_q);
    gnt_b      = can_push_s & req_b & (~req_a | ~prio_a_q);
    push_s     = gnt_a | gnt_b;
    if (gnt_b) begin
      wdata_s = data_b;
    end else begin
      wdata_s = data_a;
    end
    if (gnt_a && req_b) begin
      prio_a_d = 1'b0;
    end else if (gnt_b && req_a) begin
      prio_a_d = 1'b1;
    end else begin
      prio_a_d = prio_a_q;
    end
  end

  // Queue bookkeeping; a flush clears everything regardless of push/pop.
  always_comb begin
    rd_ptr_inc_s = rd_ptr_q + AW'(1'b1);
    head_s       = mem_q[rd_ptr_q];
    next_s       = mem_q[rd_ptr_inc_s];
    timeout_s    = (timer_q == {TW{1'b0}});
    multi_s      = (count_q > CW'(1'b1));
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_inc_s;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // Next-state logic of the display FSM.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!empty_s) begin
            state_d = ST_SHOW;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SHOW: begin
          if (!timeout_s) begin
            state_d = ST_SHOW;
`ifdef SEG_SCHED_GAP_EN
          end else begin
            state_d = ST_GAP;
          end
`else
          end else if (multi_s) begin
            state_d = ST_SHOW;
          end else begin
            state_d = ST_IDLE;
          end
`endif
        end
`ifdef SEG_SCHED_GAP_EN
        ST_GAP: begin
          if (!timeout_s) begin
            state_d = ST_GAP;
          end else if (!empty_s) begin
            state_d = ST_SHOW;
          end else begin
            state_d = ST_IDLE;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: display word, dwell/gap timer and the pop strobe.
  always_comb begin
    pop_s   = 1'b0;
    timer_d = timer_q;
    seg_d   = seg_q;
    if (flush) begin
      timer_d = {TW{1'b0}};
      seg_d   = {DATA_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!empty_s) begin
            seg_d   = head_s;
            timer_d = DWELL_LOAD;
          end else begin
            seg_d   = {DATA_W{1'b0}};
            timer_d = {TW{1'b0}};
          end
        end
        ST_SHOW: begin
          if (!timeout_s) begin
            timer_d = timer_q - TW'(1'b1);
          end else begin
            pop_s = 1'b1;
`ifdef SEG_SCHED_GAP_EN
            seg_d   = {DATA_W{1'b0}};
            timer_d = GAP_LOAD;
`else
            // next_s is valid only because more than one entry is queued
            if (multi_s) begin
              seg_d   = next_s;
              timer_d = DWELL_LOAD;
            end else begin
              seg_d   = {DATA_W{1'b0}};
              timer_d = {TW{1'b0}};
            end
`endif
          end
        end
`ifdef SEG_SCHED_GAP_EN
        ST_GAP: begin
          if (!timeout_s) begin
            timer_d = timer_q - TW'(1'b1);
          end else if (!empty_s) begin
            seg_d   = head_s;
            timer_d = DWELL_LOAD;
          end else begin
            seg_d   = {DATA_W{1'b0}};
            timer_d = {TW{1'b0}};
          end
        end
`endif
        default: begin
          seg_d   = {DATA_W{1'b0}};
          timer_d = {TW{1'b0}};
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= {TW{1'b0}};
      seg_q    <= {DATA_W{1'b0}};
      busy_q   <= 1'b0;
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      prio_a_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      seg_q    <= seg_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      prio_a_q <= prio_a_d;
    end
  end

  // Queue storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wdata_s;
    end
  end

  assign seg_out = seg_q;
  assign busy    = busy_q;
  assign full    = full_s;
  assign empty   = empty_s;
  assign count   = count_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler with DEPTH=4, DWELL_CYCLES=4, GAP_CYCLES=2.
module tb_seg_display_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, req_a, req_b, flush;
  logic [23:0] data_a, data_b;
  logic        gnt_a, gnt_b, busy, full, empty;
  logic [23:0] seg_out;
  logic [2:0]  count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seg_display_scheduler #(
    .DATA_W(24), .DEPTH(4), .DWELL_CYCLES(4), .GAP_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .flush(flush),
    .seg_out(seg_out), .busy(busy), .full(full), .empty(empty), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; flush = 1'b0;
    data_a = 24'h000000; data_b = 24'h000000;
    tick(); tick();
    chk("rst_seg", 32'(seg_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    rst_n = 1'b1;
    tick();

`ifdef SEG_SCHED_GAP_EN
    req_a = 1'b1; data_a = 24'h111111; #1;
    chk("gap_gnt1", 32'(gnt_a), 32'h1);
    tick();
    data_a = 24'h222222; #1;
    chk("gap_gnt2", 32'(gnt_a), 32'h1);
    tick();
    req_a = 1'b0;
    for (int i = 0; i < 4; i++) begin chk("gap_w1", 32'(seg_out), 32'h111111); tick(); end
    for (int i = 0; i < 2; i++) begin
      chk("gap_blank1", 32'(seg_out), 32'h0);
      chk("gap_busy1", 32'(busy), 32'h1);
      tick();
    end
    for (int i = 0; i < 4; i++) begin chk("gap_w2", 32'(seg_out), 32'h222222); tick(); end
    for (int i = 0; i < 2; i++) begin
      chk("gap_blank2", 32'(seg_out), 32'h0);
      chk("gap_busy2", 32'(busy), 32'h1);
      tick();
    end
    chk("gap_idle_busy", 32'(busy), 32'h0);
    chk("gap_idle_seg", 32'(seg_out), 32'h0);
    chk("gap_idle_empty", 32'(empty), 32'h1);
`else
    // Single push from A into an empty queue
    req_a = 1'b1; data_a = 24'h123456; #1;
    chk("t1_gnt_a", 32'(gnt_a), 32'h1);
    chk("t1_gnt_b", 32'(gnt_b), 32'h0);
    tick();
    req_a = 1'b0;
    chk("t1_seg_pre", 32'(seg_out), 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t1_seg", 32'(seg_out), 32'h123456);
      chk("t1_busy", 32'(busy), 32'h1);
      tick();
    end
    chk("t1_seg_end", 32'(seg_out), 32'h0);
    chk("t1_busy_end", 32'(busy), 32'h0);
    chk("t1_empty_end", 32'(empty), 32'h1);

    // Both ports contending: grants alternate starting with A
    req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_a = 24'hA00000 | 24'(i);
      data_b = 24'hB00000 | 24'(i);
      #1;
      chk("t2_gnt_a", 32'(gnt_a), 32'((i % 2) == 0));
      chk("t2_gnt_b", 32'(gnt_b), 32'((i % 2) == 1));
      tick();
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("t2_count", 32'(count), 32'h4);
    chk("t2_full", 32'(full), 32'h1);
    chk("t2_w0", 32'(seg_out), 32'hA00000);
    tick(); tick();
    chk("t2_w1", 32'(seg_out), 32'hB00001);
    chk("t2_count_pop", 32'(count), 32'h3);
    repeat (4) tick();
    chk("t2_w2", 32'(seg_out), 32'hA00002);
    repeat (4) tick();
    chk("t2_w3", 32'(seg_out), 32'hB00003);
    repeat (4) tick();
    chk("t2_seg_end", 32'(seg_out), 32'h0);
    chk("t2_busy_end", 32'(busy), 32'h0);

    // Five pushes from A against a four-entry queue
    req_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_a = 24'hC00001 + 24'(i);
      #1;
      chk("t3_gnt", 32'(gnt_a), 32'h1);
      tick();
    end
    chk("t3_full", 32'(full), 32'h1);
    chk("t3_count", 32'(count), 32'h4);
    data_a = 24'hC00005; #1;
    chk("t3_blocked0", 32'(gnt_a), 32'h0);
    tick();
    chk("t3_blocked1", 32'(gnt_a), 32'h0);
    tick();
    chk("t3_count_pop", 32'(count), 32'h3);
    chk("t3_gnt5", 32'(gnt_a), 32'h1);
    chk("t3_w2", 32'(seg_out), 32'hC00002);
    tick();
    req_a = 1'b0;
    chk("t3_count_refill", 32'(count), 32'h4);
    repeat (11) tick();
    chk("t3_w5", 32'(seg_out), 32'hC00005);
    repeat (4) tick();
    chk("t3_seg_end", 32'(seg_out), 32'h0);
    chk("t3_busy_end", 32'(busy), 32'h0);

    // Flush during the second dwell cycle with three words queued
    req_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_a = 24'hD00001 + 24'(i);
      tick();
    end
    req_a = 1'b0; flush = 1'b1; req_b = 1'b1; data_b = 24'hEEEEEE; #1;
    chk("t4_seg_pre", 32'(seg_out), 32'hD00001);
    chk("t4_count_pre", 32'(count), 32'h3);
    chk("t4_gnt_b", 32'(gnt_b), 32'h0);
    tick();
    flush = 1'b0; req_b = 1'b0;
    chk("t4_seg", 32'(seg_out), 32'h0);
    chk("t4_count", 32'(count), 32'h0);
    chk("t4_empty", 32'(empty), 32'h1);
    chk("t4_busy", 32'(busy), 32'h0);
    tick();
    chk("t4_still_empty", 32'(empty), 32'h1);
    chk("t4_still_idle", 32'(busy), 32'h0);

    // Reset mid-display restores priority to A
    req_a = 1'b1; req_b = 1'b1; data_a = 24'hF0000A; data_b = 24'hF0000B; #1;
    chk("t5_gnt_a_first", 32'(gnt_a), 32'h1);
    tick();
    req_a = 1'b0; #1;
    chk("t5_gnt_b", 32'(gnt_b), 32'h1);
    tick();
    req_b = 1'b0;
    tick();
    chk("t5_busy_pre", 32'(busy), 32'h1);
    chk("t5_count_pre", 32'(count), 32'h2);
    rst_n = 1'b0; req_a = 1'b1; #1;
    chk("t5_gnt_in_rst", 32'(gnt_a), 32'h0);
    tick();
    chk("t5_seg", 32'(seg_out), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_count", 32'(count), 32'h0);
    chk("t5_empty", 32'(empty), 32'h1);
    rst_n = 1'b1; req_b = 1'b1; #1;
    chk("t5_gnt_a_post", 32'(gnt_a), 32'h1);
    chk("t5_gnt_b_post", 32'(gnt_b), 32'h0);
    tick();
    req_a = 1'b0; req_b = 1'b0;
    chk("t5_count_post", 32'(count), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
